// File: rtl/sm_arith_pkg.sv
// Shared sign-magnitude arithmetic definitions.
//   op_e   : operation select (add / subtract)
//   SM_W   : widest magnitude the helper function handles
//   sm_add : sign-magnitude add of two operands whose signs are already
//            effective (subtraction folded into sign_b). Returns {sign, mag}.
//            A zero magnitude always comes back with sign 0.
package sm_arith_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  localparam int SM_W = 64;

  function automatic logic [SM_W:0] sm_add(
    input logic            sign_a,
    input logic [SM_W-1:0] mag_a,
    input logic            sign_b,
    input logic [SM_W-1:0] mag_b
  );
    logic            s;
    logic [SM_W-1:0] m;
    if (sign_a == sign_b) begin
      m = mag_a + mag_b;
      s = sign_a;
    end else if (mag_a >= mag_b) begin
      m = mag_a - mag_b;
      s = sign_a;
    end else begin
      m = mag_b - mag_a;
      s = sign_b;
    end
    // -0 never leaves this function, whatever the operands were
    if (m == '0) s = 1'b0;
    return {s, m};
  endfunction

endpackage

// File: rtl/sign_magnitude_core.sv
// Combinational sign-magnitude add/compare/subtract.
//   sign_a, mag_a : operand A
//   sign_b, mag_b : operand B with op already folded into its sign
//   sum           : {sign, DATA_WIDTH-bit magnitude}; never overflows
module sign_magnitude_core #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  sign_a,
  input  logic [DATA_WIDTH-2:0] mag_a,
  input  logic                  sign_b,
  input  logic [DATA_WIDTH-2:0] mag_b,
  output logic [DATA_WIDTH:0]   sum
);
  import sm_arith_pkg::*;

  logic [SM_W:0]   res;
  logic [SM_W-1:0] unused_hi;

  // Magnitudes are zero-extended to the helper's width; the true result
  // magnitude fits in DATA_WIDTH bits, so the upper bits are always zero.
  assign res       = sm_add(sign_a, SM_W'(mag_a), sign_b, SM_W'(mag_b));
  assign sum       = {res[SM_W], res[DATA_WIDTH-1:0]};
  assign unused_hi = res[SM_W-1:0] >> DATA_WIDTH;

endmodule

// File: rtl/sign_magnitude_addsub_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor with valid/ready on
// both sides.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake (a, b, op)
//   a, b                : DATA_WIDTH-bit sign-magnitude operands (MSB = sign)
//   op                  : 0 = a+b, 1 = a-b
//   out_valid/out_ready : result handshake
//   sum                 : DATA_WIDTH+1-bit sign-magnitude result
// S1 registers the operands with B's effective sign, S2 registers the
// result. One global enable stalls both stages while the output is held.
module sign_magnitude_addsub_pipe #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   sum
);
  import sm_arith_pkg::*;

  localparam int STAGES = 2;
  localparam int MW     = DATA_WIDTH - 1;

  typedef struct packed {
    logic          sa;
    logic [MW-1:0] ma;
    logic          sb;  // effective sign of B: sign_b ^ (op == OP_SUB)
    logic [MW-1:0] mb;
  } s1_t;

  logic [STAGES:1]     vld_pipe;
  s1_t                 s1_q;
  logic [DATA_WIDTH:0] sum_q;
  logic [DATA_WIDTH:0] core_sum;
  logic                en;

  // Whole pipe moves together; a full S2 that is not being taken freezes it.
  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];
  assign sum       = sum_q;

  sign_magnitude_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .sign_a (s1_q.sa),
    .mag_a  (s1_q.ma),
    .sign_b (s1_q.sb),
    .mag_b  (s1_q.mb),
    .sum    (core_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      sum_q    <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) begin
        s1_q <= '{sa: a[DATA_WIDTH-1],
                  ma: a[MW-1:0],
                  sb: b[DATA_WIDTH-1] ^ (op_e'(op) == OP_SUB),
                  mb: b[MW-1:0]};
      end
      // sum keeps its last value across bubbles
      if (vld_pipe[1]) sum_q <= core_sum;
    end
  end

endmodule

// File: tb/tb_sign_magnitude_addsub_pipe.sv
module tb_sign_magnitude_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0: width 4, index 1: width 8, index 2: width 2
  logic [7:0] a_s [3];
  logic [7:0] b_s [3];
  logic       op_s [3];
  logic       iv_s [3];
  logic       ordy_s [3];
  logic       ir_s [3];
  logic       ov_s [3];
  logic [8:0] sum_s [3];
  bit         rnd [3];
  bit         lat_chk [3];
  int         qsize [3];

  task automatic chk(input bit ok, input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got=%b want=%b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer arithmetic, re-encoded as sign-magnitude.
  function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b, input logic op);
    int mask, ma, mb, va, vb, r;
    mask = (1 << (w - 1)) - 1;
    ma = int'(a) & mask;
    mb = int'(b) & mask;
    va = a[w-1] ? -ma : ma;
    vb = (b[w-1] ^ op) ? -mb : mb;
    r  = va + vb;
    return (r < 0) ? 9'((1 << w) | (-r)) : 9'(r);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 2;
    logic [W:0] sw;

    sign_magnitude_addsub_pipe #(.DATA_WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv_s[g]),
      .in_ready  (ir_s[g]),
      .a         (a_s[g][W-1:0]),
      .b         (b_s[g][W-1:0]),
      .op        (op_s[g]),
      .out_valid (ov_s[g]),
      .out_ready (ordy_s[g]),
      .sum       (sw)
    );
    assign sum_s[g] = 9'(sw);

    logic [8:0] expq[$];
    int         accq[$];
    bit         pv, pr;
    logic [8:0] ps;

    // Compare process: every negedge, judge the handshakes of the next edge.
    always @(negedge clk or negedge rst_n) begin
      logic [8:0] e;
      int t;
      if (!rst_n) begin
        expq.delete();
        accq.delete();
        pv = 1'b0; pr = 1'b0; ps = '0;
        qsize[g] = 0;
      end else begin
        if (pv && !pr)
          chk(ov_s[g] && sum_s[g] == ps, $sformatf("stall_hold_w%0d", W), sum_s[g], ps);
        if (!ov_s[g])
          chk(!$isunknown(sum_s[g]), $sformatf("idle_sum_known_w%0d", W), sum_s[g], ps);
        if (ov_s[g] && ordy_s[g]) begin
          if (expq.size() == 0) begin
            chk(1'b0, $sformatf("spurious_out_w%0d", W), sum_s[g], 9'd0);
          end else begin
            e = expq.pop_front();
            t = accq.pop_front();
            chk(sum_s[g] === e, $sformatf("sum_w%0d", W), sum_s[g], e);
            if (lat_chk[g]) chk(cyc - t == 2, "latency", 9'(cyc - t), 9'd2);
          end
        end
        if (iv_s[g] && ir_s[g]) begin
          expq.push_back(model(W, a_s[g], b_s[g], op_s[g]));
          accq.push_back(cyc);
        end
        qsize[g] = expq.size();
        pv = ov_s[g]; pr = ordy_s[g]; ps = sum_s[g];
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input int g, input logic [7:0] a, input logic [7:0] b, input logic op);
    int n;
    n = 0;
    iv_s[g] = 1'b1; a_s[g] = a; b_s[g] = b; op_s[g] = op;
    @(negedge clk);
    while (!ir_s[g] && n < 300) begin
      n++;
      @(posedge clk); #1;
      if (rnd[g]) ordy_s[g] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (n >= 300) chk(1'b0, "send_timeout", 9'(g), 9'd0);
    @(posedge clk); #1;
    iv_s[g] = 1'b0;
    if (rnd[g]) ordy_s[g] = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int g, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd[g]) ordy_s[g] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    rnd[g] = 1'b0;
    ordy_s[g] = 1'b1;
    while (qsize[g] != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(qsize[g] == 0, "drain_empty", 9'(qsize[g]), 9'd0);
    chk(!ov_s[g], "drain_idle", 9'(ov_s[g]), 9'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      a_s[g] = '0; b_s[g] = '0; op_s[g] = 1'b0; iv_s[g] = 1'b0; ordy_s[g] = 1'b1;
      rnd[g] = 1'b0; lat_chk[g] = 1'b0;
    end
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      chk(!ov_s[g], "rst_out_valid", 9'(ov_s[g]), 9'd0);
      chk(sum_s[g] == 9'd0, "rst_sum", sum_s[g], 9'd0);
      chk(ir_s[g], "rst_in_ready", 9'(ir_s[g]), 9'd1);
    end

    // Pin the reference model to hand-computed values
    chk(model(4, 8'b0100, 8'b0001, 1'b0) == 9'b00101, "pin_4p1", model(4, 8'b0100, 8'b0001, 1'b0), 9'b00101);
    chk(model(4, 8'b0100, 8'b1001, 1'b0) == 9'b00011, "pin_4m1", model(4, 8'b0100, 8'b1001, 1'b0), 9'b00011);
    chk(model(4, 8'b1111, 8'b0001, 1'b0) == 9'b10110, "pin_m7p1", model(4, 8'b1111, 8'b0001, 1'b0), 9'b10110);
    chk(model(4, 8'b1001, 8'b1010, 1'b0) == 9'b10011, "pin_m1m2", model(4, 8'b1001, 8'b1010, 1'b0), 9'b10011);
    chk(model(4, 8'b1111, 8'b1110, 1'b0) == 9'b11101, "pin_m7m6", model(4, 8'b1111, 8'b1110, 1'b0), 9'b11101);
    chk(model(4, 8'b0100, 8'b0100, 1'b1) == 9'b00000, "pin_4s4", model(4, 8'b0100, 8'b0100, 1'b1), 9'b00000);
    chk(model(4, 8'b1000, 8'b0000, 1'b0) == 9'b00000, "pin_negzero", model(4, 8'b1000, 8'b0000, 1'b0), 9'b00000);
    chk(model(4, 8'b0011, 8'b1101, 1'b1) == 9'b01000, "pin_3sm5", model(4, 8'b0011, 8'b1101, 1'b1), 9'b01000);
    chk(model(4, 8'b1011, 8'b1011, 1'b1) == 9'b00000, "pin_m3sm3", model(4, 8'b1011, 8'b1011, 1'b1), 9'b00000);
    chk(model(2, 8'b01, 8'b01, 1'b0) == 9'b010, "pin_w2_add", model(2, 8'b01, 8'b01, 1'b0), 9'b010);
    chk(model(2, 8'b11, 8'b01, 1'b1) == 9'b110, "pin_w2_sub", model(2, 8'b11, 8'b01, 1'b1), 9'b110);

    fork
      begin : w4
        // back-to-back stream, fixed latency
        lat_chk[0] = 1'b1;
        send(0, 8'b0100, 8'b0001, 1'b0);
        send(0, 8'b0100, 8'b1001, 1'b0);
        send(0, 8'b1111, 8'b0001, 1'b0);
        send(0, 8'b1001, 8'b1010, 1'b0);
        send(0, 8'b1111, 8'b1110, 1'b0);
        send(0, 8'b0100, 8'b0100, 1'b1);
        send(0, 8'b1000, 8'b0000, 1'b0);
        send(0, 8'b0011, 8'b1101, 1'b1);
        send(0, 8'b1011, 8'b1011, 1'b1);
        drain(0);
        lat_chk[0] = 1'b0;

        // backpressure: only two entries fit while output is held
        ordy_s[0] = 1'b0;
        fork
          begin
            send(0, 8'b0101, 8'b0010, 1'b0);
            send(0, 8'b1110, 8'b0011, 1'b0);
            send(0, 8'b0001, 8'b0111, 1'b1);
            send(0, 8'b1010, 8'b1010, 1'b0);
          end
          begin
            repeat (6) @(negedge clk);
            chk(!ir_s[0], "bp_in_ready_low", 9'(ir_s[0]), 9'd0);
            chk(ov_s[0], "bp_out_valid_high", 9'(ov_s[0]), 9'd1);
            chk(qsize[0] == 2, "bp_two_in_flight", 9'(qsize[0]), 9'd2);
            @(posedge clk); #1;
            ordy_s[0] = 1'b1;
          end
        join
        drain(0);

        // exhaustive sweep plus random traffic with random backpressure
        rnd[0] = 1'b1;
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            for (int o = 0; o < 2; o++) begin
              send(0, 8'(x), 8'(y), 1'(o));
              if ($urandom_range(0, 3) == 0) idle(0, 1);
            end
        for (int i = 0; i < 488; i++) begin
          send(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 2) == 0) idle(0, $urandom_range(1, 2));
        end
        drain(0);
      end
      begin : w8
        rnd[1] = 1'b1;
        for (int i = 0; i < 1000; i++) begin
          send(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 2) == 0) idle(1, 1);
        end
        drain(1);
      end
      begin : w2
        send(2, 8'b01, 8'b01, 1'b0);
        send(2, 8'b11, 8'b01, 1'b1);
        for (int x = 0; x < 4; x++)
          for (int y = 0; y < 4; y++)
            for (int o = 0; o < 2; o++)
              send(2, 8'(x), 8'(y), 1'(o));
        drain(2);
      end
    join

    // async reset mid-stream drops in-flight results
    ordy_s[0] = 1'b1;
    send(0, 8'b0011, 8'b0010, 1'b0);
    send(0, 8'b0101, 8'b0001, 1'b0);
    #1 chk(ov_s[0], "pre_reset_valid", 9'(ov_s[0]), 9'd1);
    #1 rst_n = 1'b0;
    #1;
    chk(!ov_s[0], "rst_async_valid", 9'(ov_s[0]), 9'd0);
    chk(sum_s[0] == 9'd0, "rst_async_sum", sum_s[0], 9'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk(!ov_s[0], "post_reset_idle", 9'(ov_s[0]), 9'd0);
    send(0, 8'b0111, 8'b1001, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk(ov_s[0], "post_reset_first_valid", 9'(ov_s[0]), 9'd1);
    chk(sum_s[0] == 9'b01000, "post_reset_first_sum", sum_s[0], 9'b01000);
    @(posedge clk); #1;
    drain(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
